cpu_step_ctrl: RTL and testbench

Run-control sequencer for the single-cycle MIPS core. It replaces the fixed divide-by-4 processor clock with a programmable clock-enable (`cpu_ce`) on the system clock. It also gates that enable under RUN / HALT / STEP / BURST commands from the debug front end, and stops on a datapath breakpoint. The core's state registers load only on cycles where `cpu_ce`=1.

---
 rtl/cpu_step_pkg.sv | 24 ++
 rtl/cpu_step_ctrl_if.sv | 34 +++
 rtl/clk_div_tick.sv | 39 +++
 rtl/cpu_step_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_pkg.sv
// Shared definitions for the CPU run-control sequencer.
//   op_e    : debug command op codes carried on cmd_op
//   state_e : sequencer state as presented on the state output
//   *_DEF   : default widths and reset divisor
package cpu_step_pkg;

  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned DEFAULT_DIV_DEF = 4;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STEP  = 2'b10,
    OP_BURST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Debug front end <-> run-control sequencer bundle.
//   cfg_valid/cfg_div/cfg_ready       : divisor update handshake
//   cmd_valid/cmd_op/cmd_count/ready  : run-control command handshake
//   brk                               : datapath breakpoint level
//   cpu_ce/state/done/brk_hit/retired : sequencer status toward core and debugger
// master = debug front end, slave = cpu_step_ctrl.
interface cpu_step_ctrl_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_ready;
  logic             brk;
  logic             cpu_ce;
  logic [1:0]       state;
  logic             done;
  logic             brk_hit;
  logic [31:0]      retired;

  modport master (
    output cfg_valid, cfg_div, cmd_valid, cmd_op, cmd_count, brk,
    input  cfg_ready, cmd_ready, cpu_ce, state, done, brk_hit, retired
  );

  modport slave (
    input  cfg_valid, cfg_div, cmd_valid, cmd_op, cmd_count, brk,
    output cfg_ready, cmd_ready, cpu_ce, state, done, brk_hit, retired
  );
endinterface

// File: rtl/clk_div_tick.sv
// Programmable modulo counter producing a tick every div cycles while enabled.
//   clk, reset : system clock, asynchronous active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance the counter
//   div        : modulus, expected >= 1 (0 behaves as 2**WIDTH)
//   tick       : high while the counter sits at div-1
module clk_div_tick #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div - WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run-control sequencer for the single-cycle MIPS core. Produces a registered
// clock enable (cpu_ce) every div_q system clocks while running, under
// RUN/HALT/STEP/BURST control, and stops on a datapath breakpoint.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : cpu_step_ctrl_if slave (config, command, brk, status outputs)
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic             clk,
  input logic             reset,
  cpu_step_ctrl_if.slave  bus
);

  localparam logic [DIV_W-1:0] RESET_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             ce_q, ce_d;
  logic             done_q, done_d;
  logic             brk_hit_q, brk_hit_d;
  logic [31:0]      retired_q, retired_d;

  logic tick;
  logic idle;
  logic cmd_acc;
  logic halt_acc;

  assign idle     = (state_q == ST_IDLE);
  assign cmd_acc  = bus.cmd_valid && bus.cmd_ready;
  assign halt_acc = cmd_acc && (bus.cmd_op == OP_HALT);

  // Held at zero in IDLE, so every accepted command starts a fresh period.
  clk_div_tick #(
    .WIDTH (DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (idle),
    .en    (!idle),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    remaining_d = remaining_q;
    ce_d        = 1'b0;
    done_d      = 1'b0;
    brk_hit_d   = brk_hit_q;
    retired_d   = retired_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          div_d = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
        end
        if (cmd_acc && (bus.cmd_op != OP_HALT)) begin
          brk_hit_d = 1'b0;
          case (bus.cmd_op)
            OP_RUN: state_d = ST_RUN;
            OP_STEP: begin
              state_d     = ST_COUNT;
              remaining_d = CNT_W'(1);
            end
            OP_BURST: begin
              // Zero-length burst completes immediately without issuing.
              if (bus.cmd_count == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = ST_COUNT;
                remaining_d = bus.cmd_count;
              end
            end
            default: ;
          endcase
        end
      end

      ST_RUN, ST_COUNT: begin
        if (bus.brk || halt_acc) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          remaining_d = '0;
          if (bus.brk) begin
            brk_hit_d = 1'b1;
          end
        end else if (tick) begin
          ce_d      = 1'b1;
          retired_d = retired_q + 32'd1;
          if (state_q == ST_COUNT) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= RESET_DIV;
      remaining_q <= '0;
      ce_q        <= 1'b0;
      done_q      <= 1'b0;
      brk_hit_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      remaining_q <= remaining_d;
      ce_q        <= ce_d;
      done_q      <= done_d;
      brk_hit_q   <= brk_hit_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.cfg_ready = idle;
  assign bus.cmd_ready = idle || (bus.cmd_op == OP_HALT);
  assign bus.cpu_ce    = ce_q;
  assign bus.state     = state_q;
  assign bus.done      = done_q;
  assign bus.brk_hit   = brk_hit_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;
  import cpu_step_pkg::*;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEF_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cpu_step_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus_if ();

  cpu_step_ctrl #(
    .DIV_W       (DIV_W),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference model: pulses are scheduled at absolute edge numbers
  // (accept edge + k*div), rather than by tracking a divider counter.
  int          edge_no   = 0;
  int          m_mode    = 0;   // 0 idle, 1 run, 2 count
  int          m_div     = DEF_DIV;
  int          m_next    = 0;
  int          m_left    = 0;
  bit          m_ce      = 0;
  bit          m_done    = 0;
  bit          m_brk_hit = 0;
  int unsigned m_retired = 0;

  always @(posedge clk) begin : model
    int op;
    bit acc;
    bit halt;
    edge_no++;
    if (reset) begin
      m_mode = 0; m_div = DEF_DIV; m_next = 0; m_left = 0;
      m_ce = 0; m_done = 0; m_brk_hit = 0; m_retired = 0;
    end else begin
      op   = int'(bus_if.cmd_op);
      acc  = bus_if.cmd_valid && (m_mode == 0 || op == 0);
      halt = acc && (op == 0);
      m_ce   = 0;
      m_done = 0;
      if (m_mode == 0) begin
        if (bus_if.cfg_valid) m_div = (bus_if.cfg_div == 0) ? 1 : int'(bus_if.cfg_div);
        if (acc && op != 0) begin
          m_brk_hit = 0;
          m_next    = edge_no + m_div;
          if (op == 1) m_mode = 1;
          else if (op == 2) begin m_mode = 2; m_left = 1; end
          else if (bus_if.cmd_count == 0) m_done = 1;
          else begin m_mode = 2; m_left = int'(bus_if.cmd_count); end
        end
      end else if (bus_if.brk || halt) begin
        m_mode = 0;
        m_done = 1;
        if (bus_if.brk) m_brk_hit = 1;
      end else if (edge_no == m_next) begin
        m_ce = 1;
        m_retired++;
        m_next += m_div;
        if (m_mode == 2) begin
          m_left--;
          if (m_left == 0) begin m_mode = 0; m_done = 1; end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational readies, clock it,
  // then check every registered output against the model.
  task automatic cyc(input bit cv, input int cd, input bit mv, input int op, input int cnt,
                     input bit b);
    bus_if.cfg_valid = cv;
    bus_if.cfg_div   = DIV_W'(cd);
    bus_if.cmd_valid = mv;
    bus_if.cmd_op    = 2'(op);
    bus_if.cmd_count = CNT_W'(cnt);
    bus_if.brk       = b;
    #1;
    chk("cfg_ready", 32'(bus_if.cfg_ready), 32'(m_mode == 0));
    chk("cmd_ready", 32'(bus_if.cmd_ready), 32'((m_mode == 0) || (op == 0)));
    @(posedge clk);
    @(negedge clk);
    chk("cpu_ce",  32'(bus_if.cpu_ce),  32'(m_ce));
    chk("done",    32'(bus_if.done),    32'(m_done));
    chk("state",   32'(bus_if.state),   32'(m_mode));
    chk("brk_hit", 32'(bus_if.brk_hit), 32'(m_brk_hit));
    chk("retired", bus_if.retired,      m_retired);
    if (bus_if.cpu_ce) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int start;
    int k;
    start = pulses;
    k = 0;
    while ((pulses - start) < n && k < budget) begin
      idle(1);
      k++;
    end
    chk("pulse_wait", 32'(pulses - start), 32'(n));
  endtask

  // Advance until the next edge is a scheduled issue edge.
  task automatic to_tick(input int budget);
    int k;
    k = 0;
    while (m_next != edge_no + 1 && k < budget) begin
      idle(1);
      k++;
    end
    chk("to_tick", 32'(m_next), 32'(edge_no + 1));
  endtask

  initial begin
    bus_if.cfg_valid = 0; bus_if.cfg_div = '0; bus_if.cmd_valid = 0;
    bus_if.cmd_op = '0; bus_if.cmd_count = '0; bus_if.brk = 0;

    // Reset
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state",   32'(bus_if.state),   32'd0);
    chk("rst_cpu_ce",  32'(bus_if.cpu_ce),  32'd0);
    chk("rst_retired", bus_if.retired,      32'd0);
    reset = 0;
    idle(2);

    // RUN at default divisor 4: first pulse 4 edges after accept
    pulses = 0;
    cyc(0, 0, 1, OP_RUN, 0, 0);
    idle(3);
    chk("run_no_early_ce", 32'(bus_if.cpu_ce), 32'd0);
    idle(1);
    chk("run_first_ce", 32'(bus_if.cpu_ce), 32'd1);
    wait_pulses(9, 60);
    chk("run_retired_10", bus_if.retired, 32'd10);
    cyc(0, 0, 1, OP_HALT, 0, 0);
    chk("halt_done", 32'(bus_if.done), 32'd1);
    idle(2);

    // cfg_div 0 -> divisor 1, STEP gives one pulse with done
    cyc(1, 0, 0, 0, 0, 0);
    pulses = 0;
    cyc(0, 0, 1, OP_STEP, 0, 0);
    idle(1);
    chk("step_ce",    32'(bus_if.cpu_ce), 32'd1);
    chk("step_done",  32'(bus_if.done),   32'd1);
    chk("step_state", 32'(bus_if.state),  32'd0);
    idle(3);
    chk("step_pulses", 32'(pulses), 32'd1);

    // BURST 5 at divisor 3, then zero-length BURST
    cyc(1, 3, 0, 0, 0, 0);
    pulses = 0;
    cyc(0, 0, 1, OP_BURST, 5, 0);
    idle(15);
    chk("burst_last_done", 32'(bus_if.done), 32'd1);
    chk("burst_pulses",    32'(pulses),      32'd5);
    idle(2);
    cyc(0, 0, 1, OP_BURST, 0, 0);
    chk("burst0_done", 32'(bus_if.done), 32'd1);
    idle(3);
    chk("burst0_retired", bus_if.retired, 32'd16);

    // Breakpoint on a tick at divisor 2, then STEP clears brk_hit
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, OP_RUN, 0, 0);
    idle(3);
    to_tick(10);
    cyc(0, 0, 0, 0, 0, 1);
    chk("brk_no_ce", 32'(bus_if.cpu_ce),  32'd0);
    chk("brk_hit",   32'(bus_if.brk_hit), 32'd1);
    chk("brk_done",  32'(bus_if.done),    32'd1);
    idle(2);
    cyc(0, 0, 1, OP_STEP, 0, 0);
    chk("brk_cleared", 32'(bus_if.brk_hit), 32'd0);
    idle(4);

    // Config and RUN stall while running; HALT on a tick suppresses the pulse
    cyc(0, 0, 1, OP_RUN, 0, 0);
    idle(1);
    cyc(1, 7, 1, OP_RUN, 0, 0);
    to_tick(10);
    cyc(0, 0, 1, OP_HALT, 0, 0);
    chk("halt_tick_ce",    32'(bus_if.cpu_ce), 32'd0);
    chk("halt_tick_state", 32'(bus_if.state),  32'd0);
    cyc(0, 0, 1, OP_STEP, 0, 0);
    idle(1);
    chk("div_kept_early", 32'(bus_if.cpu_ce), 32'd0);
    idle(1);
    chk("div_kept_ce",    32'(bus_if.cpu_ce), 32'd1);
    idle(2);

    // Reset in the middle of a burst with 3 pulses remaining
    cyc(0, 0, 1, OP_BURST, 6, 0);
    begin
      int k;
      k = 0;
      while (m_left != 3 && k < 30) begin idle(1); k++; end
      chk("mid_burst_left", 32'(m_left), 32'd3);
    end
    reset = 1;
    #1;
    chk("mrst_ce",      32'(bus_if.cpu_ce),  32'd0);
    chk("mrst_done",    32'(bus_if.done),    32'd0);
    chk("mrst_state",   32'(bus_if.state),   32'd0);
    chk("mrst_brk_hit", 32'(bus_if.brk_hit), 32'd0);
    chk("mrst_retired", bus_if.retired,      32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    pulses = 0;
    idle(10);
    chk("mrst_no_ce", 32'(pulses), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 5)),
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)), $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
